// File: rtl/ps_config_pkg.sv
// Shared types and constants for the passive-serial configuration target.
// Holds the controller state encoding, the accepted MSEL code, the CRC-16
// constants and the ns-to-cycles helper used to size the internal timer.
package ps_config_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_STATUS_WAIT,
    ST_CONFIG,
    ST_INIT,
    ST_USER,
    ST_ERROR
  } state_t;

  localparam logic [3:0]  MSEL_PS  = 4'b0000;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Whole clock cycles covered by a delay given in ns
  function automatic int unsigned ns_to_cycles(input int unsigned ns,
                                               input int unsigned period);
    return ns / period;
  endfunction

endpackage

// File: rtl/ps_crc16.sv
// Running CRC-16-CCITT over completed configuration bytes.
// Bytes are folded in LSB-first; the register restarts from CRC_INIT on clear.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   clear         restart the CRC (held while the target is in HOLD)
//   byte_valid    byte_data holds a completed byte to fold in
//   byte_data     completed byte
//   crc           current CRC value
module ps_crc16
  import ps_config_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [15:0] crc
);

  // One byte through the bit-serial CCITT shift, bit 0 first
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ CRC_POLY;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset || clear)  crc <= CRC_INIT;
    else if (byte_valid) crc <= crc_byte(crc, byte_data);
  end

endmodule

// File: rtl/ps_config_target.sv
// Device-side passive-serial configuration controller (Cyclone IV E style).
// Answers nCONFIG with nSTATUS/CONF_DONE timing, shifts the bitstream in on
// DCLK/DATA0 (LSB first per byte) and then reports INIT_DONE.
// Optional trailer CRC check is built when PS_TARGET_CRC_EN is defined.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   n_config      host nCONFIG, low clears the device
//   msel          mode select, only standard PS accepted
//   dclk, data0   host config clock and serial data (oversampled)
//   n_status      low while clearing, waiting or in error
//   conf_done     high once the full image has arrived
//   init_done     high in user mode
//   error         high while in ERROR
//   byte_count    bytes received so far
module ps_config_target
  import ps_config_pkg::*;
#(
  parameter int unsigned PERIOD      = 10,
  parameter int unsigned IMAGE_BYTES = 1024,
  parameter int unsigned TSTATUS_NS  = 2000,
  parameter int unsigned TCD2UM_NS   = 5000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             n_config,
  input  logic [3:0]                       msel,
  input  logic                             dclk,
  input  logic                             data0,
  output logic                             n_status,
  output logic                             conf_done,
  output logic                             init_done,
  output logic                             error,
  output logic [$clog2(IMAGE_BYTES+1)-1:0] byte_count
);

  localparam int unsigned CNT_W       = $clog2(IMAGE_BYTES + 1);
  localparam int unsigned TSTATUS_CYC = ns_to_cycles(TSTATUS_NS, PERIOD);
  localparam int unsigned TCD2UM_CYC  = ns_to_cycles(TCD2UM_NS, PERIOD);
  localparam int unsigned TIMER_MAX   = (TSTATUS_CYC > TCD2UM_CYC) ? TSTATUS_CYC : TCD2UM_CYC;
  localparam int unsigned TIMER_W     = $clog2(TIMER_MAX + 1);

  state_t               state, state_n;
  logic                 ncfg_q, dclk_q, dclk_qq, data0_q;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic [7:0]           shift, shift_n;
  logic [CNT_W-1:0]     byte_count_n;
  logic                 n_status_n, conf_done_n, init_done_n, error_n;
  logic                 dclk_rise_c;
  logic                 crc_ok_c;

  // Single-stage input capture; data0 is taken alongside dclk
  always_ff @(posedge clock) begin
    if (reset) begin
      ncfg_q  <= 1'b0;
      dclk_q  <= 1'b0;
      dclk_qq <= 1'b0;
      data0_q <= 1'b0;
    end else begin
      ncfg_q  <= n_config;
      dclk_q  <= dclk;
      dclk_qq <= dclk_q;
      data0_q <= data0;
    end
  end

  assign dclk_rise_c = dclk_q & ~dclk_qq;

`ifdef PS_TARGET_CRC_EN
  logic [15:0] crc;
  logic [7:0]  crc_lo;
  logic [7:0]  byte_done_c;
  logic        byte_end_c;
  logic        crc_byte_c;

  assign byte_done_c = {data0_q, shift[6:0]};
  assign byte_end_c  = (state == ST_CONFIG) && dclk_rise_c && (bit_cnt == 3'd7);
  // Only payload bytes feed the CRC; the two trailer bytes are the reference
  assign crc_byte_c  = byte_end_c && (byte_count < CNT_W'(IMAGE_BYTES - 2));

  ps_crc16 u_crc (
    .clock      (clock),
    .reset      (reset),
    .clear      (state == ST_HOLD),
    .byte_valid (crc_byte_c),
    .byte_data  (byte_done_c),
    .crc        (crc)
  );

  // Low trailer byte is held until the high byte completes
  always_ff @(posedge clock) begin
    if (reset) crc_lo <= 8'h00;
    else if (byte_end_c && (byte_count == CNT_W'(IMAGE_BYTES - 2))) crc_lo <= byte_done_c;
  end

  assign crc_ok_c = ({byte_done_c, crc_lo} == crc);
`else
  assign crc_ok_c = 1'b1;
`endif

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_HOLD;
      timer      <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_count <= '0;
      n_status   <= 1'b0;
      conf_done  <= 1'b0;
      init_done  <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      byte_count <= byte_count_n;
      n_status   <= n_status_n;
      conf_done  <= conf_done_n;
      init_done  <= init_done_n;
      error      <= error_n;
    end
  end

  // Next state, datapath and output decode (outputs follow the next state)
  always_comb begin
    state_n      = state;
    timer_n      = timer;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    byte_count_n = byte_count;
    n_status_n   = 1'b0;
    conf_done_n  = 1'b0;
    init_done_n  = 1'b0;
    error_n      = 1'b0;

    unique case (state)
      ST_HOLD: begin
        timer_n      = '0;
        bit_cnt_n    = '0;
        shift_n      = '0;
        byte_count_n = '0;
        if (ncfg_q) state_n = (msel == MSEL_PS) ? ST_STATUS_WAIT : ST_ERROR;
      end
      ST_STATUS_WAIT: begin
        if (timer == TIMER_W'(TSTATUS_CYC - 1)) begin
          timer_n = '0;
          state_n = ST_CONFIG;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
      ST_CONFIG: begin
        if (dclk_rise_c) begin
          shift_n[bit_cnt] = data0_q;
          bit_cnt_n        = bit_cnt + 3'd1;
          if ((bit_cnt == 3'd7) && (byte_count < CNT_W'(IMAGE_BYTES))) begin
            byte_count_n = byte_count + CNT_W'(1);
            if (byte_count == CNT_W'(IMAGE_BYTES - 1))
              state_n = crc_ok_c ? ST_INIT : ST_ERROR;
          end
        end
      end
      ST_INIT: begin
        if (timer == TIMER_W'(TCD2UM_CYC - 1)) begin
          timer_n = '0;
          state_n = ST_USER;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
      ST_USER, ST_ERROR: ;
      default: state_n = ST_HOLD;
    endcase

    // nCONFIG low wins over every other transition
    if (!ncfg_q) begin
      state_n      = ST_HOLD;
      timer_n      = '0;
      bit_cnt_n    = '0;
      shift_n      = '0;
      byte_count_n = '0;
    end

    n_status_n  = (state_n == ST_CONFIG) || (state_n == ST_INIT) || (state_n == ST_USER);
    conf_done_n = (state_n == ST_INIT) || (state_n == ST_USER);
    init_done_n = (state_n == ST_USER);
    error_n     = (state_n == ST_ERROR);
  end

endmodule
